// File: rtl/aes_ct_serializer_pkg.sv
// Shared types and constants for the AES ciphertext byte serializer.
package aes_ser_pkg;
   localparam int         BLK_W         = 128;
   localparam int         BYTES_PER_BLK = 16;
   localparam logic [7:0] SYNC_DEF      = 8'hA5;

   typedef enum logic [1:0] {IDLE, SYNC, DATA} ser_state_e;

   // Byte i of a block, MSB first (i=0 -> blk[127:120]).
   function automatic logic [7:0] blk_byte(input logic [BLK_W-1:0] blk, input logic [3:0] i);
      return blk[(BLK_W - 8) - 8*int'(i) +: 8];
   endfunction
endpackage

// File: rtl/aes_ct_serializer_if.sv
// Ciphertext capture input and framed byte-stream output of the serializer.
interface aes_ct_serializer_if;
   import aes_ser_pkg::*;
   logic [BLK_W-1:0] din;
   logic             din_vld;
   logic [7:0]       byte_out;
   logic             byte_vld;
   logic             byte_rdy;
   logic             frame_start;

   modport master (output din, din_vld, byte_rdy, input byte_out, byte_vld, frame_start);
   modport slave  (input din, din_vld, byte_rdy, output byte_out, byte_vld, frame_start);
endinterface

// File: rtl/aes_ct_serializer_ct_fifo.sv
// Block FIFO with registered level/full/empty and a fall-through head.
module ct_fifo
   import aes_ser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [BLK_W-1:0]           wr_data,
   input  logic                       rd_en,
   output logic                       accept,
   output logic [BLK_W-1:0]           head,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DEPTH-1:0][BLK_W-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [LW-1:0]               lvl_nxt;
   logic                        rd_ok;

   // A full FIFO still accepts a write when the head leaves on the same edge.
   always_comb begin
      accept  = wr_en && (!full || rd_en);
      rd_ok   = rd_en && !empty;
      lvl_nxt = level + LW'(accept) - LW'(rd_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= lvl_nxt;
         full  <= (lvl_nxt == LW'(DEPTH));
         empty <= (lvl_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/aes_ct_serializer.sv
// Captures AES ciphertexts on din_vld rising edges and streams them as
// SYNC_BYTE + 16 data bytes per frame over a valid/ready byte handshake.
module aes_ct_serializer
   import aes_ser_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
   parameter int         OVF_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   aes_ct_serializer_if.slave     bus,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [OVF_W-1:0]       overflow_cnt,
   output logic                   busy
);
   localparam int LW = $clog2(DEPTH) + 1;

   ser_state_e       state, state_n;
   logic [3:0]       idx, idx_n;
   logic [7:0]       bo_n;
   logic             bv_n, fs_n, busy_n;
   logic             din_vld_q, wr_ev, xfer, pop, accept, full, empty;
   logic [BLK_W-1:0] head;
   logic [LW-1:0]    lvl_nxt;

   ct_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ev),
      .wr_data (bus.din),
      .rd_en   (pop),
      .accept  (accept),
      .head    (head),
      .level   (fifo_level),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      wr_ev   = bus.din_vld && !din_vld_q;
      xfer    = bus.byte_vld && bus.byte_rdy;
      pop     = (state == DATA) && xfer && (idx == 4'(BYTES_PER_BLK - 1));
      lvl_nxt = fifo_level + LW'(accept) - LW'(pop);
      state_n = state;
      idx_n   = idx;
      bo_n    = bus.byte_out;
      bv_n    = bus.byte_vld;
      fs_n    = bus.frame_start;
      case (state)
         IDLE: if (!empty) begin
            state_n = SYNC;
            bo_n    = SYNC_BYTE;
            bv_n    = 1'b1;
            fs_n    = 1'b1;
         end
         SYNC: if (xfer) begin
            state_n = DATA;
            idx_n   = 4'd0;
            bo_n    = blk_byte(head, 4'd0);
            fs_n    = 1'b0;
         end
         DATA: if (xfer) begin
            if (!pop) begin
               idx_n = idx + 4'd1;
               bo_n  = blk_byte(head, idx + 4'd1);
            // A write landing on the pop edge is always accepted, so it counts as "more".
            end else if (fifo_level > LW'(1) || wr_ev) begin
               state_n = SYNC;
               bo_n    = SYNC_BYTE;
               fs_n    = 1'b1;
            end else begin
               state_n = IDLE;
               bv_n    = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE) || (lvl_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         idx             <= 4'd0;
         bus.byte_out    <= 8'd0;
         bus.byte_vld    <= 1'b0;
         bus.frame_start <= 1'b0;
         din_vld_q       <= 1'b0;
         overflow_cnt    <= '0;
         busy            <= 1'b0;
      end else begin
         state           <= state_n;
         idx             <= idx_n;
         bus.byte_out    <= bo_n;
         bus.byte_vld    <= bv_n;
         bus.frame_start <= fs_n;
         din_vld_q       <= bus.din_vld;
         busy            <= busy_n;
         if (wr_ev && full && !pop && overflow_cnt != '1)
            overflow_cnt <= overflow_cnt + OVF_W'(1);
      end
   end
endmodule

// File: tb/tb_aes_ct_serializer.sv
// Randomized and directed bench for aes_ct_serializer against a queue-based frame model.
module tb_aes_ct_serializer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  fifo_level;
   logic [15:0] overflow_cnt;
   logic        busy;

   aes_ct_serializer_if ifc ();

   aes_ct_serializer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .OVF_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (ifc),
      .fifo_level   (fifo_level),
      .overflow_cnt (overflow_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: blocks waiting or in flight, bytes of head already sent, stream active.
   logic [127:0] mq[$];
   int pos = 0;
   bit active = 1'b0;
   bit prev_v = 1'b0;
   int ovf = 0;
   bit armed = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_byte();
      logic [127:0] sh;
      if (pos == 0) return 8'hA5;
      sh = mq[0] >> (8 * (16 - pos));
      return sh[7:0];
   endfunction

   task automatic check_out();
      if (!armed) return;
      chk("byte_vld", 128'(ifc.byte_vld), 128'(active));
      if (active) begin
         chk("byte_out", 128'(ifc.byte_out), 128'(exp_byte()));
         chk("frame_start", 128'(ifc.frame_start), 128'(pos == 0));
      end
      chk("fifo_level", 128'(fifo_level), 128'(mq.size()));
      chk("overflow_cnt", 128'(overflow_cnt), 128'(ovf));
      chk("busy", 128'(busy), 128'(active || mq.size() > 0));
   endtask

   task automatic model_edge(input bit r, input bit v, input logic [127:0] d, input bit rd);
      int pre;
      bit xfer, pop;
      if (!r) begin
         mq.delete();
         pos = 0; active = 1'b0; prev_v = 1'b0; ovf = 0; armed = 1'b1;
         return;
      end
      pre  = mq.size();
      xfer = active && rd;
      pop  = xfer && (pos == 16);
      if (v && !prev_v) begin
         if (pre < DEPTH || pop) mq.push_back(d);
         else if (ovf < 65535) ovf++;
      end
      prev_v = v;
      if (xfer) pos++;
      if (pop) begin
         void'(mq.pop_front());
         pos = 0;
      end
      if (!active) active = (pre > 0);
      else if (pop) active = (mq.size() > 0);
   endtask

   task automatic step(input bit r, input bit v, input logic [127:0] d, input bit rd);
      @(negedge clk);
      check_out();
      rst_n = r; ifc.din_vld = v; ifc.din = d; ifc.byte_rdy = rd;
      @(posedge clk);
      model_edge(r, v, d, rd);
   endtask

   initial begin
      logic [127:0] k;
      int ovf_before;
      bit done;
      ifc.din = '0; ifc.din_vld = 1'b0; ifc.byte_rdy = 1'b0;

      repeat (3) step(1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("rst_byte_out", 128'(ifc.byte_out), 128'd0);
      chk("rst_byte_vld", 128'(ifc.byte_vld), 128'd0);

      // single block, one-cycle pulse
      k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      step(1'b1, 1'b1, k, 1'b1);
      repeat (25) step(1'b1, 1'b0, k, 1'b1);
      #1;
      chk("single_busy", 128'(busy), 128'd0);
      chk("single_level", 128'(fifo_level), 128'd0);

      // held level captures once
      k = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
      repeat (40) step(1'b1, 1'b1, k, 1'b1);
      repeat (25) step(1'b1, 1'b0, k, 1'b1);
      #1;
      chk("level_ovf", 128'(overflow_cnt), 128'd0);

      // backpressure 1,0,0,1
      k = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
      step(1'b1, 1'b1, k, 1'b1);
      for (int i = 0; i < 90; i++) step(1'b1, 1'b0, k, (i % 4 == 0) || (i % 4 == 3));

      // overflow: six blocks, sink stalled
      for (int i = 0; i < 6; i++) begin
         k = {4{32'h1000_0000 + 32'(i)}};
         step(1'b1, 1'b1, k, 1'b0);
         step(1'b1, 1'b0, k, 1'b0);
      end
      #1;
      chk("ovf_level", 128'(fifo_level), 128'd4);
      chk("ovf_cnt", 128'(overflow_cnt), 128'd2);
      repeat (80) step(1'b1, 1'b0, '0, 1'b1);

      // write coinciding with pop while full
      for (int i = 0; i < 4; i++) begin
         k = {4{32'h2000_0000 + 32'(i)}};
         step(1'b1, 1'b1, k, 1'b0);
         step(1'b1, 1'b0, k, 1'b0);
      end
      ovf_before = ovf;
      done = 1'b0;
      for (int i = 0; i < 110; i++) begin
         if (!done && active && pos == 16) begin
            step(1'b1, 1'b1, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1'b1);
            done = 1'b1;
            #1;
            chk("simul_level", 128'(fifo_level), 128'd4);
            chk("simul_ovf", 128'(overflow_cnt), 128'(ovf_before));
         end else begin
            step(1'b1, 1'b0, '0, 1'b1);
         end
      end
      chk("simul_seen", 128'(done), 128'd1);

      // reset after data byte 5
      k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      step(1'b1, 1'b1, k, 1'b1);
      for (int i = 0; i < 40 && !(active && pos == 7); i++) step(1'b1, 1'b0, k, 1'b1);
      chk("midrst_reached", 128'(active && pos == 7), 128'd1);
      step(1'b0, 1'b0, k, 1'b1);
      #1;
      chk("midrst_vld", 128'(ifc.byte_vld), 128'd0);
      chk("midrst_level", 128'(fifo_level), 128'd0);
      chk("midrst_ovf", 128'(overflow_cnt), 128'd0);
      step(1'b1, 1'b1, ~k, 1'b1);
      repeat (25) step(1'b1, 1'b0, ~k, 1'b1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         step(($urandom % 400) != 0, ($urandom % 6) == 0, k, ($urandom % 3) != 0);
      end
      repeat (120) step(1'b1, 1'b0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
- Downstream consumer of the AES encryption core's output.
- Captures each 128-bit ciphertext when the core's data-valid rises, buffers it in a small FIFO, and emits it as a framed byte stream over a valid/ready handshake. Each frame is a sync byte followed by 16 data bytes.
- The byte stream feeds the UART/trace logger, so ciphertexts can be checked off-chip while the AES keeps toggling for the ring-oscillator sensor.

Parameters:
- DEPTH, 4, FIFO entries in 128-bit blocks; must be a power of 2, at least 2.
- SYNC_BYTE, 8'hA5, header byte sent before every block.
- OVF_W, 16, width of the dropped-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- din  in  128  ciphertext from the AES core (Dout).
- din_vld  in  1  AES data valid (Dvld); may be a pulse or a level.
- byte_out  out  8  serialized byte.
- byte_vld  out  1  byte_out is valid.
- byte_rdy  in  1  sink accepts the byte.
- frame_start  out  1  high while byte_out is the SYNC_BYTE.
- fifo_level  out  $clog2(DEPTH)+1  occupied entries.
- overflow_cnt  out  OVF_W  blocks dropped because the FIFO was full; saturating.
- busy  out  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: byte_out=0, byte_vld=0, frame_start=0, fifo_level=0, overflow_cnt=0, busy=0, FSM=IDLE, FIFO pointers=0, din_vld_q=0.
- Reset mid-frame aborts the frame immediately. Partial frames are never resumed, and buffered blocks are discarded.
- Capture:
  - din_vld_q registers din_vld every cycle.
  - A write event is din_vld=1 and din_vld_q=0 (rising edge), so a held level captures exactly once.
  - din is written into the FIFO on the same edge.
- Full FIFO:
  - If the FIFO is full and no pop happens in the same cycle, the block is dropped and overflow_cnt increments. It saturates at all-ones.
  - A write coinciding with a pop while full is accepted, and the level is unchanged.
- FIFO pop occurs on the transfer of data byte 15. The head entry stays stable while it is being serialized.
- Handshake:
  - A transfer happens on a cycle with byte_vld=1 and byte_rdy=1.
  - While byte_vld=1 and byte_rdy=0, byte_out and frame_start hold stable.
  - byte_vld never drops without a transfer, except on reset.
  - byte_rdy may be held high continuously; the stream then runs at one byte per clock.
- FSM states: IDLE, SYNC, DATA; a 4-bit byte index idx.
  - IDLE: when the FIFO is not empty, go to SYNC. byte_out=SYNC_BYTE, byte_vld=1, frame_start=1.
  - SYNC: on transfer, go to DATA with idx=0. byte_out = head[127:120], frame_start=0.
  - DATA:
    - On a transfer with idx<15: idx+1, and byte_out = head[127-8*(idx+1) -: 8]. Byte order is MSB first.
    - On a transfer with idx=15: pop. If the FIFO still holds another block after the pop (including a block written on the same cycle), go directly to SYNC with no idle bubble. Otherwise go to IDLE with byte_vld=0.
- Latency: a din_vld rising edge sampled at edge T into an empty, idle block gives byte_vld=1 with SYNC_BYTE after edge T+1. A frame takes at least 17 cycles.
- fifo_level and busy are registered and update on the same edge as the write or pop.

Decomposition:
- Package aes_ser_pkg:
  - FSM state enum (IDLE, SYNC, DATA);
  - BLK_W=128;
  - BYTES_PER_BLK=16;
  - default SYNC_BYTE.
- Sub-module ct_fifo:
  - synchronous FIFO with DEPTH entries of 128 bits;
  - registered level, full and empty;
  - write-when-full allowed only with a simultaneous pop;
  - first-word-fall-through head output.
- The top level holds the edge detect, FSM, output registers and overflow counter.

Test Plan:
- Single block: din=128'h00112233_44556677_8899AABB_CCDDEEFF pulsed 1 cycle, byte_rdy=1 → bytes A5,00,11,…,FF on 17 consecutive cycles. frame_start only on A5; then IDLE, busy=0, fifo_level=0.
- Level input: din_vld held high for 40 cycles with a constant din → exactly one frame; overflow_cnt=0.
- Backpressure: byte_rdy toggles 1,0,0,1 repeating → byte_out/frame_start stable while stalled; same 17-byte sequence with no loss or duplication.
- Overflow: byte_rdy=0, six din_vld pulses with distinct din → fifo_level=4, overflow_cnt=2. Release byte_rdy → four back-to-back frames of the first four blocks with no idle cycle between them.
- Simultaneous pop and write: FIFO full, pulse din_vld on the cycle data byte 15 transfers → block accepted, fifo_level stays 4, overflow_cnt unchanged.
- Reset mid-frame: rst_n=0 for 1 cycle after data byte 5 → next edge byte_vld=0, fifo_level=0, overflow_cnt=0. A new pulse then yields a full frame starting with A5.
